// File: rtl/sdr_pkg.sv
// -----------------------------------------------------------------------------
// sdr_pkg
// Shared constants and width helpers for the SDR receive path.
//   ADC_W     : signed ADC sample width
//   NCO_W     : signed NCO sin/cos width (matches mnco fsin_o/fcos_o)
//   clog2     : ceiling log2, used for counter and accumulator sizing
//   acc_width : accumulator width for a mixer product summed over DECIM terms
// -----------------------------------------------------------------------------
package sdr_pkg;

    localparam int ADC_W = 10;
    localparam int NCO_W = 10;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // A sum of 2^k products of PW bits fits in PW + k bits, so the
    // integrate-and-dump accumulator can never wrap.
    function automatic int acc_width(input int adc_w, input int nco_w, input int decim);
        return adc_w + nco_w + clog2(decim);
    endfunction

endpackage

// File: rtl/sdr_round_sat.sv
// -----------------------------------------------------------------------------
// sdr_round_sat
// Combinational round-half-up, arithmetic right shift and saturation.
//   din_i  in   IN_W   signed value to scale
//   dout_o out  OUT_W  signed, rounded, saturated result
//   sat_o  out  1      result was clipped to the OUT_W range
// The rounding add is done one bit wider than the input so it cannot overflow.
// Assumes IN_W + 1 > OUT_W (true for the mixer: ACC_W >= 21).
// -----------------------------------------------------------------------------
module sdr_round_sat
    import sdr_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o,
    output logic                    sat_o
);

    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] MAXV = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    // ~MAX == -MAX-1, i.e. the most negative OUT_W value
    localparam logic signed [EXT_W-1:0] MINV = ~MAXV;

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;
    logic                    over;
    logic                    under;

    always_comb begin
        biased  = EXT_W'(din_i) + HALF;
        shifted = biased >>> SHIFT;
        over    = (shifted > MAXV);
        under   = (shifted < MINV);
        sat_o   = over | under;
        if (over) begin
            dout_o = MAXV[OUT_W-1:0];
        end else if (under) begin
            dout_o = MINV[OUT_W-1:0];
        end else begin
            dout_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/nco_mixer_decim.sv
// -----------------------------------------------------------------------------
// nco_mixer_decim
// Quadrature down-mixer plus integrate-and-dump decimator fed by the mnco NCO.
// Each accepted ADC sample is multiplied by cos (I) and -sin (Q); DECIM products
// are summed and one rounded, saturated I/Q pair is emitted per frame.
//   clk        in   1      system clock
//   reset_n    in   1      async active-low reset
//   clken      in   1      global clock enable (shared with mnco)
//   adc_i      in   ADC_W  signed ADC sample
//   adc_valid  in   1      adc_i valid
//   fsin_i     in   NCO_W  signed NCO sine
//   fcos_i     in   NCO_W  signed NCO cosine
//   nco_valid  in   1      NCO output valid
//   ovf_clr_i  in   1      synchronous clear of ovf_o (ignores clken)
//   i_o, q_o   out  OUT_W  signed decimated I/Q
//   out_valid  out  1      one-cycle pulse when i_o/q_o update
//   ovf_o      out  1      sticky saturation flag
// Pipeline (enabled edges): E0 capture, E1 multiply, E2 accumulate or dump.
// -----------------------------------------------------------------------------
module nco_mixer_decim
    import sdr_pkg::*;
#(
    parameter int ADC_W = sdr_pkg::ADC_W,
    parameter int NCO_W = sdr_pkg::NCO_W,
    parameter int DECIM = 16,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic signed [ADC_W-1:0] adc_i,
    input  logic                    adc_valid,
    input  logic signed [NCO_W-1:0] fsin_i,
    input  logic signed [NCO_W-1:0] fcos_i,
    input  logic                    nco_valid,
    input  logic                    ovf_clr_i,
    output logic signed [OUT_W-1:0] i_o,
    output logic signed [OUT_W-1:0] q_o,
    output logic                    out_valid,
    output logic                    ovf_o
);

    localparam int PW    = ADC_W + NCO_W;
    localparam int CNT_W = clog2(DECIM);
    localparam int ACC_W = acc_width(ADC_W, NCO_W, DECIM);

    // s1: captured operands
    logic signed [ADC_W-1:0] adc_q;
    logic signed [NCO_W-1:0] sin_q;
    logic signed [NCO_W-1:0] cos_q;
    // s2: products
    logic signed [PW-1:0]    pi_q, pi_d;
    logic signed [PW-1:0]    pq_q, pq_d;
    // vld_pipe_q[0] = s1 valid, vld_pipe_q[1] = s2 valid
    logic [1:0]              vld_pipe_q;

    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] sum_i, sum_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic signed [OUT_W-1:0] i_q, i_d, i_rs;
    logic signed [OUT_W-1:0] q_q, q_d, q_rs;
    logic                    ov_q, ov_d;
    logic                    ovf_q, ovf_d;
    logic                    sat_i, sat_q;
    logic                    accept;
    logic                    dump;

    assign accept = clken & adc_valid & nco_valid;

    always_comb begin
        // Operands are widened before the multiply so the product is full PW bits.
        pi_d  = PW'(adc_q) * PW'(cos_q);
        // |adc*sin| <= 2^(PW-2), so negation cannot overflow PW bits.
        pq_d  = -(PW'(adc_q) * PW'(sin_q));
        // The dump includes the product arriving on the same edge.
        sum_i = acc_i_q + ACC_W'(pi_q);
        sum_q = acc_q_q + ACC_W'(pq_q);
        dump  = vld_pipe_q[1] && (cnt_q == CNT_W'(DECIM - 1));

        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        q_d     = q_q;
        ov_d    = 1'b0;
        if (vld_pipe_q[1]) begin
            if (dump) begin
                i_d     = i_rs;
                q_d     = q_rs;
                ov_d    = 1'b1;
                acc_i_d = '0;
                acc_q_d = '0;
                cnt_d   = '0;
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end

        // Set beats clear when both land on the same edge.
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (clken && dump && (sat_i || sat_q)) begin
            ovf_d = 1'b1;
        end
    end

    sdr_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_rs_i (
        .din_i  (sum_i),
        .dout_o (i_rs),
        .sat_o  (sat_i)
    );

    sdr_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_rs_q (
        .din_i  (sum_q),
        .dout_o (q_rs),
        .sat_o  (sat_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_q      <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
            pi_q       <= '0;
            pq_q       <= '0;
            vld_pipe_q <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            cnt_q      <= '0;
            i_q        <= '0;
            q_q        <= '0;
            ov_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (clken) begin
                vld_pipe_q <= {vld_pipe_q[0], accept};
                adc_q      <= adc_i;
                sin_q      <= fsin_i;
                cos_q      <= fcos_i;
                pi_q       <= pi_d;
                pq_q       <= pq_d;
                acc_i_q    <= acc_i_d;
                acc_q_q    <= acc_q_d;
                cnt_q      <= cnt_d;
                i_q        <= i_d;
                q_q        <= q_d;
                ov_q       <= ov_d;
            end else begin
                // Everything else freezes; the strobe must not repeat.
                ov_q <= 1'b0;
            end
        end
    end

    assign i_o       = i_q;
    assign q_o       = q_q;
    assign out_valid = ov_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_nco_mixer_decim.sv
// -----------------------------------------------------------------------------
// tb_nco_mixer_decim
// Directed bench for nco_mixer_decim. Two instances share all inputs: dut with
// default parameters and dut4 with SHIFT=4 for the saturation case.
// -----------------------------------------------------------------------------
module tb_nco_mixer_decim;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              clken;
    logic signed [9:0] adc_i;
    logic              adc_valid;
    logic signed [9:0] fsin;
    logic signed [9:0] fcos;
    logic              nco_valid;
    logic              ovf_clr;
    logic signed [15:0] i_o, q_o, i4, q4;
    logic              out_valid, ovf_o, ov4, ovf4;

    int checks   = 0;
    int failures = 0;
    int lat, early, after;
    int acc_n, post, gap_err;
    logic en, av, nv, will, inc;

    always #5 clk = ~clk;

    nco_mixer_decim dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .adc_i     (adc_i),
        .adc_valid (adc_valid),
        .fsin_i    (fsin),
        .fcos_i    (fcos),
        .nco_valid (nco_valid),
        .ovf_clr_i (ovf_clr),
        .i_o       (i_o),
        .q_o       (q_o),
        .out_valid (out_valid),
        .ovf_o     (ovf_o)
    );

    nco_mixer_decim #(.SHIFT(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .adc_i     (adc_i),
        .adc_valid (adc_valid),
        .fsin_i    (fsin),
        .fcos_i    (fcos),
        .nco_valid (nco_valid),
        .ovf_clr_i (ovf_clr),
        .i_o       (i4),
        .q_o       (q4),
        .out_valid (ov4),
        .ovf_o     (ovf4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, return 1 time unit after it.
    task automatic drive(input logic v_adc, input logic v_nco, input logic en_i,
                         input int adc, input int sn, input int cs);
        adc_valid = v_adc;
        nco_valid = v_nco;
        clken     = en_i;
        adc_i     = 10'(adc);
        fsin      = 10'(sn);
        fcos      = 10'(cs);
        @(posedge clk);
        #1;
    endtask

    // 16 back-to-back accepts, then idle until the dump strobe.
    // lat   : idle edges after the last accept until out_valid is seen (-1 if never)
    // early : strobes seen while the frame was still being fed
    // after : out_valid on the edge following the strobe
    task automatic run_frame(input int adc, input int sn, input int cs,
                             output int lat_o, output int early_o, output int after_o);
        early_o = 0;
        lat_o   = -1;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, 1'b1, adc, sn, cs);
            if (out_valid) early_o++;
        end
        for (int k = 1; k <= 8 && lat_o < 0; k++) begin
            drive(1'b0, 1'b0, 1'b1, adc, sn, cs);
            if (out_valid) lat_o = k;
        end
        drive(1'b0, 1'b0, 1'b1, adc, sn, cs);
        after_o = int'(out_valid);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clken = 1'b1; adc_valid = 1'b0; nco_valid = 1'b0;
        adc_i = '0; fsin = '0; fcos = '0; ovf_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_i", int'(i_o), 0);
        chk("rst_q", int'(q_o), 0);
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_ovf", int'(ovf_o), 0);
        chk("rst_ovf4", int'(ovf4), 0);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);

        // DC mix: 100*511*16 = 817600; (817600+128)>>8 = 3194
        run_frame(100, 0, 511, lat, early, after);
        chk("dc_i", int'(i_o), 3194);
        chk("dc_q", int'(q_o), 0);
        chk("dc_ovf", int'(ovf_o), 0);
        chk("dc_lat", lat, 2);
        chk("dc_early", early, 0);
        chk("dc_pulse_width", after, 0);
        run_frame(100, 0, 511, lat, early, after);
        chk("dc2_i", int'(i_o), 3194);
        chk("dc2_lat", lat, 2);

        // Q sign: -(-100*511) = +51100 per sample
        run_frame(-100, 511, 0, lat, early, after);
        chk("qs_i", int'(i_o), 0);
        chk("qs_q", int'(q_o), 3194);

        // Rounding: sums 128, 112, -128 with +128 bias, >>8
        run_frame(1, 0, 8, lat, early, after);
        chk("rnd_p8", int'(i_o), 1);
        run_frame(1, 0, 7, lat, early, after);
        chk("rnd_p7", int'(i_o), 0);
        run_frame(-1, 0, 8, lat, early, after);
        chk("rnd_m8", int'(i_o), 0);

        // Saturation: I sum = +4194304, Q sum = -4194304.
        // SHIFT=4: +262144 clips to 32767, -262144 clips to -32768.
        // SHIFT=8: +16384 and floor(-16383.5) = -16384, both in range.
        do_reset();
        run_frame(-512, -512, -512, lat, early, after);
        chk("sat4_i", int'(i4), 32767);
        chk("sat4_q", int'(q4), -32768);
        chk("sat4_ovf", int'(ovf4), 1);
        chk("sat8_i", int'(i_o), 16384);
        chk("sat8_q", int'(q_o), -16384);
        chk("sat8_ovf", int'(ovf_o), 0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        chk("sat4_ovf_sticky", int'(ovf4), 1);
        // Clear while clken=0: the clear must still take effect.
        ovf_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        ovf_clr = 1'b0;
        chk("sat4_ovf_clr", int'(ovf4), 0);
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);

        // Gaps: random valid/enable drops. Expected strobe only on the second
        // enabled edge after the 16th accept.
        do_reset();
        acc_n = 0; post = -1; gap_err = 0;
        for (int k = 0; k < 400 && post < 3; k++) begin
            en = ($urandom_range(3) != 0);
            av = ($urandom_range(3) != 0);
            nv = ($urandom_range(3) != 0);
            if (acc_n >= 16) av = 1'b0;
            will = en & av & nv;
            drive(av, nv, en, 100, 0, 511);
            inc = 1'b0;
            if (will) begin
                acc_n++;
                if (acc_n == 16) post = 0;
            end else if (post >= 0 && en) begin
                post++;
                inc = 1'b1;
            end
            if (out_valid !== (inc && post == 2)) gap_err++;
        end
        chk("gap_done", post, 3);
        chk("gap_strobe_errs", gap_err, 0);
        chk("gap_i", int'(i_o), 3194);
        chk("gap_q", int'(q_o), 0);

        // Reset mid-frame: outputs clear asynchronously, partial sum is dropped.
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, 1'b1, 100, 0, 511);
        #1 reset_n = 1'b0;
        #1;
        chk("mrst_i", int'(i_o), 0);
        chk("mrst_q", int'(q_o), 0);
        chk("mrst_vld", int'(out_valid), 0);
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        run_frame(100, 0, 511, lat, early, after);
        chk("mrst_lat", lat, 2);
        chk("mrst_early", early, 0);
        chk("mrst_i_after", int'(i_o), 3194);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
